pr_skid_stage: RTL and testbench
================================

// Module: pr_skid_stage
// PURPOSE
//  Parametrised pipeline-stage register with a valid/ready handshake. It replaces
//  fixed-width HOLD-style stage registers between CPU pipeline stages (IF/ID, ID/EX, ...).
//  Adds per-entry valid tracking, FLUSH with bubble (NOP) insertion, and an optional
//  2-entry skid buffer so that a stalled downstream stage never drops data.
//  With the skid buffer, IN_READY is registered and the stage keeps full throughput.
// PARAMETERS
//  DATA_W     64      width of payload (e.g. {PC[31:0], INSTRUCTION[31:0]})
//  NOP_VALUE  64'h0   payload driven/loaded when an entry is invalid (bubble)
//  SKID       1       1: 2-entry skid buffer, registered IN_READY; 0: single entry, combinational IN_READY
// PORTS
//  CLK        in   1       clock, all state updates on posedge
//  RESET      in   1       synchronous, active-high; highest priority
//  FLUSH      in   1       synchronous kill of all held entries (branch/jump redirect)
//  IN_VALID   in   1       upstream presents IN_DATA
//  IN_READY   out  1       stage can accept; transfer = IN_VALID & IN_READY
//  IN_DATA    in   DATA_W  upstream payload
//  OUT_VALID  out  1       OUT_DATA holds a live entry
//  OUT_READY  in   1       downstream accepts; drain = OUT_VALID & OUT_READY
//  OUT_DATA   out  DATA_W  head entry payload; equals NOP_VALUE when OUT_VALID=0
//  OCCUPANCY  out  2       live entries held (0..2; never exceeds 1 when SKID=0)
// BEHAVIOUR
//  State: main entry M {m_v, m_d}; when SKID=1 also skid entry S {s_v, s_d}. All registered.
//  OUT_VALID=m_v, OUT_DATA=m_d, OCCUPANCY=m_v+s_v. No combinational IN->OUT path.
//  Reset (RESET=1 at posedge): m_v=s_v=0, m_d=s_d=NOP_VALUE.
//   -> OUT_VALID=0, OUT_DATA=NOP_VALUE, OCCUPANCY=0, IN_READY=1 (SKID=1).
//   Reset mid-transfer discards all entries; the input presented in that cycle is not accepted.
//  FLUSH=1 (RESET=0): same effect as reset on the next edge. An input transferred in the
//   same cycle is discarded; a drain in the same cycle still counts as consumed downstream.
//  Latency: 1 cycle IN->OUT when M is empty or draining. Order is strictly FIFO.
//  SKID=1 (priority per edge, RESET > FLUSH > normal):
//   IN_READY = ~s_v (registered value, independent of OUT_READY).
//   load_m = ~m_v | OUT_READY.
//   load_m & s_v       : M<=S, S<=invalid(NOP); input not accepted (IN_READY=0).
//   load_m & ~s_v      : M<=input if transfer, else M<=invalid(NOP).
//   ~load_m & transfer : S<=input (only possible when s_v=0); M holds.
//   ~load_m & ~transfer: hold all.
//   Full (OCCUPANCY=2): IN_READY=0 until a drain moves S into M.
//   Empty: OUT_VALID=0; a drain request with OUT_VALID=0 is ignored.
//  SKID=0:
//   IN_READY = ~m_v | OUT_READY (combinational). On transfer M<=input;
//   on drain without transfer M<=invalid(NOP); otherwise hold. This is the legacy HOLD stage
//   with HOLD = ~OUT_READY.
//  Invalid entries always carry NOP_VALUE, so consumers that ignore valid see a bubble.
//  IN_DATA is sampled only on transfer; X on IN_DATA while IN_VALID=0 must not propagate.
// TESTING
//  1 Reset: RESET=1 for 2 cycles with IN_VALID=1, IN_DATA=64'hA
//    -> OUT_VALID=0, OUT_DATA=0, OCCUPANCY=0, IN_READY=1 afterwards.
//  2 Streaming: OUT_READY=1, IN_VALID=1 with data 1,2,3,4 on consecutive cycles
//    -> OUT_DATA 1,2,3,4 one cycle later, back-to-back; IN_READY stays 1.
//  3 Stall/skid (SKID=1): send 5,6,7 with OUT_READY=0
//    -> 5 in M, 6 in S, OCCUPANCY=2, IN_READY=0, 7 held upstream;
//    set OUT_READY=1 -> outputs 5,6,7 in order, with no loss or duplication.
//  4 Flush: OCCUPANCY=2 (8,9), FLUSH=1 with IN_VALID=1, IN_DATA=10
//    -> next cycle OUT_VALID=0, OUT_DATA=NOP_VALUE, OCCUPANCY=0; 10 never appears.
//  5 Simultaneous: M=11 valid, S empty, OUT_READY=1, IN_VALID=1 with 12
//    -> 11 drained, M=12 next cycle, OCCUPANCY=1; RESET+FLUSH together behaves as reset.
//  6 SKID=0 build: same stimulus as test 3
//    -> IN_READY=0 whenever m_v=1 and OUT_READY=0; OCCUPANCY never >1; order preserved.
//    Random ready/valid run vs scoreboard: 10k cycles, zero mismatches.

Source files
------------

// File: rtl/pr_skid_stage.sv
// Pipeline-stage register with valid/ready handshake, flush-to-bubble and an
// optional 2-entry skid buffer that keeps full throughput with a registered IN_READY.
module pr_skid_stage #(
    parameter int                 DATA_W    = 64,
    parameter logic [DATA_W-1:0]  NOP_VALUE = '0,
    parameter bit                 SKID      = 1'b1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              FLUSH,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [DATA_W-1:0] IN_DATA,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic [1:0]        OCCUPANCY
);

    logic              m_v;
    logic [DATA_W-1:0] m_d;
    logic              s_v;
    logic              in_xfer;
    logic              kill;

    assign kill      = RESET | FLUSH;
    assign in_xfer   = IN_VALID & IN_READY;
    assign OUT_VALID = m_v;
    assign OUT_DATA  = m_d;
    assign OCCUPANCY = {1'b0, m_v} + {1'b0, s_v};

    generate
        if (SKID) begin : g_skid
            logic              s_v_q;
            logic [DATA_W-1:0] s_d;
            logic              load_m;

            // IN_READY comes straight from a flop, so upstream never sees OUT_READY
            assign IN_READY = ~s_v_q;
            assign load_m   = ~m_v | OUT_READY;
            assign s_v      = s_v_q;

            // main / skid entry update
            always_ff @(posedge CLK) begin
                if (kill) begin
                    m_v   <= 1'b0;
                    m_d   <= NOP_VALUE;
                    s_v_q <= 1'b0;
                    s_d   <= NOP_VALUE;
                end else if (load_m) begin
                    if (s_v_q) begin
                        m_v   <= 1'b1;
                        m_d   <= s_d;
                        s_v_q <= 1'b0;
                        s_d   <= NOP_VALUE;
                    end else if (in_xfer) begin
                        m_v <= 1'b1;
                        m_d <= IN_DATA;
                    end else begin
                        m_v <= 1'b0;
                        m_d <= NOP_VALUE;
                    end
                end else if (in_xfer) begin
                    // M is stalled and full; park the accepted word behind it
                    s_v_q <= 1'b1;
                    s_d   <= IN_DATA;
                end
            end
        end else begin : g_single
            logic drain;

            // legacy HOLD stage: HOLD = ~OUT_READY
            assign IN_READY = ~m_v | OUT_READY;
            assign drain    = m_v & OUT_READY;
            assign s_v      = 1'b0;

            // single entry update
            always_ff @(posedge CLK) begin
                if (kill) begin
                    m_v <= 1'b0;
                    m_d <= NOP_VALUE;
                end else if (in_xfer) begin
                    m_v <= 1'b1;
                    m_d <= IN_DATA;
                end else if (drain) begin
                    m_v <= 1'b0;
                    m_d <= NOP_VALUE;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_pr_skid_stage.sv
// Bench for pr_skid_stage: a SKID=1 and a SKID=0 instance share one stimulus stream,
// each tracked by its own queue-based scoreboard.
module tb_pr_skid_stage;

    localparam int          DATA_W = 64;
    localparam logic [63:0] NOP0   = 64'h0;
    localparam logic [63:0] NOP1   = 64'hDEAD_BEEF_0BAD_F00D;

    logic              CLK = 1'b0;
    logic              RESET, FLUSH, IN_VALID, OUT_READY;
    logic [DATA_W-1:0] IN_DATA;
    logic              rdy0, ov0, rdy1, ov1;
    logic [DATA_W-1:0] od0, od1;
    logic [1:0]        occ0, occ1;

    int n_checks = 0;
    int n_errors = 0;
    bit mon_en   = 1'b0;

    logic [63:0] q0[$];
    logic [63:0] q1[$];

    always #5 CLK = ~CLK;

    pr_skid_stage #(.DATA_W(DATA_W), .NOP_VALUE(NOP0), .SKID(1'b1)) u_skid (
        .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
        .IN_VALID(IN_VALID), .IN_READY(rdy0), .IN_DATA(IN_DATA),
        .OUT_VALID(ov0), .OUT_READY(OUT_READY), .OUT_DATA(od0), .OCCUPANCY(occ0)
    );

    pr_skid_stage #(.DATA_W(DATA_W), .NOP_VALUE(NOP1), .SKID(1'b0)) u_single (
        .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
        .IN_VALID(IN_VALID), .IN_READY(rdy1), .IN_DATA(IN_DATA),
        .OUT_VALID(ov1), .OUT_READY(OUT_READY), .OUT_DATA(od1), .OCCUPANCY(occ1)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // scoreboards: compare on drain, push on accepted transfer, clear on reset/flush
    always @(negedge CLK) begin
        if (mon_en) begin
            chk("occ_skid", 64'(occ0), 64'(q0.size()));
            chk("vld_skid", 64'(ov0), 64'(q0.size() != 0));
            chk("rdy_skid", 64'(rdy0), 64'(q0.size() < 2));
            if (!ov0) chk("nop_skid", od0, NOP0);
            if (ov0 && OUT_READY && !RESET) begin
                if (q0.size() == 0) chk("extra_skid", 64'd1, 64'd0);
                else                chk("data_skid", od0, q0.pop_front());
            end
            if (RESET || FLUSH)          q0.delete();
            else if (IN_VALID && rdy0)   q0.push_back(IN_DATA);
        end
    end

    always @(negedge CLK) begin
        if (mon_en) begin
            chk("occ_single", 64'(occ1), 64'(q1.size()));
            chk("vld_single", 64'(ov1), 64'(q1.size() != 0));
            chk("rdy_single", 64'(rdy1), 64'((q1.size() == 0) || OUT_READY));
            if (!ov1) chk("nop_single", od1, NOP1);
            if (ov1 && OUT_READY && !RESET) begin
                if (q1.size() == 0) chk("extra_single", 64'd1, 64'd0);
                else                chk("data_single", od1, q1.pop_front());
            end
            if (RESET || FLUSH)          q1.delete();
            else if (IN_VALID && rdy1)   q1.push_back(IN_DATA);
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RESET     = 1'b1;
        FLUSH     = 1'b0;
        IN_VALID  = 1'b1;
        IN_DATA   = 64'hA;
        OUT_READY = 1'b0;

        // reset with a pending input
        step();
        step();
        RESET    = 1'b0;
        IN_VALID = 1'b0;
        @(negedge CLK);
        chk("rst_vld", 64'(ov0), 64'd0);
        chk("rst_data", od0, 64'd0);
        chk("rst_occ", 64'(occ0), 64'd0);
        chk("rst_rdy", 64'(rdy0), 64'd1);
        chk("rst_data_single", od1, NOP1);
        chk("rst_occ_single", 64'(occ1), 64'd0);
        mon_en = 1'b1;

        // streaming 1..4
        OUT_READY = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            IN_VALID = (i <= 4);
            IN_DATA  = 64'(i);
            @(negedge CLK);
            if (i >= 2) chk("stream_out", od0, 64'(i - 1));
            if (i <= 4) chk("stream_rdy", 64'(rdy0), 64'd1);
        end

        // stall: 5 in M, 6 in S, 7 held
        step();
        OUT_READY = 1'b0;
        IN_VALID  = 1'b1;
        IN_DATA   = 64'd5;
        step();
        IN_DATA   = 64'd6;
        step();
        IN_DATA   = 64'd7;
        @(negedge CLK);
        chk("stall_occ", 64'(occ0), 64'd2);
        chk("stall_rdy", 64'(rdy0), 64'd0);
        chk("stall_out", od0, 64'd5);
        chk("stall_rdy_single", 64'(rdy1), 64'd0);
        step();
        OUT_READY = 1'b1;
        @(negedge CLK);
        chk("release_out5", od0, 64'd5);
        chk("release_rdy", 64'(rdy0), 64'd0);
        step();
        @(negedge CLK);
        chk("release_out6", od0, 64'd6);
        chk("release_rdy7", 64'(rdy0), 64'd1);
        step();
        IN_VALID = 1'b0;
        @(negedge CLK);
        chk("release_out7", od0, 64'd7);
        step();

        // flush while full, with an input offered
        OUT_READY = 1'b0;
        IN_VALID  = 1'b1;
        IN_DATA   = 64'd8;
        step();
        IN_DATA   = 64'd9;
        step();
        FLUSH     = 1'b1;
        IN_DATA   = 64'd10;
        @(negedge CLK);
        chk("flush_pre_occ", 64'(occ0), 64'd2);
        step();
        FLUSH    = 1'b0;
        IN_VALID = 1'b0;
        @(negedge CLK);
        chk("flush_vld", 64'(ov0), 64'd0);
        chk("flush_data", od0, NOP0);
        chk("flush_occ", 64'(occ0), 64'd0);

        // simultaneous drain and fill, then RESET+FLUSH together
        step();
        IN_VALID = 1'b1;
        IN_DATA  = 64'd11;
        step();
        OUT_READY = 1'b1;
        IN_DATA   = 64'd12;
        @(negedge CLK);
        chk("simul_out11", od0, 64'd11);
        step();
        OUT_READY = 1'b0;
        IN_DATA   = 64'd13;
        @(negedge CLK);
        chk("simul_out12", od0, 64'd12);
        chk("simul_occ", 64'(occ0), 64'd1);
        step();
        RESET   = 1'b1;
        FLUSH   = 1'b1;
        IN_DATA = 64'd14;
        step();
        RESET    = 1'b0;
        FLUSH    = 1'b0;
        IN_VALID = 1'b0;
        @(negedge CLK);
        chk("rstflush_occ", 64'(occ0), 64'd0);
        chk("rstflush_vld", 64'(ov0), 64'd0);
        chk("rstflush_rdy", 64'(rdy0), 64'd1);
        chk("rstflush_data_single", od1, NOP1);

        // random ready/valid traffic
        for (int c = 0; c < 10000; c++) begin
            step();
            IN_VALID  = ($urandom_range(0, 9) < 7);
            IN_DATA   = IN_VALID ? {$urandom(), $urandom()} : 64'hFFFF_0000_FFFF_0000;
            OUT_READY = ($urandom_range(0, 9) < 6);
            FLUSH     = ($urandom_range(0, 199) == 0);
        end

        // drain everything
        step();
        IN_VALID  = 1'b0;
        FLUSH     = 1'b0;
        OUT_READY = 1'b1;
        repeat (4) step();
        @(negedge CLK);
        chk("final_occ", 64'(occ0), 64'd0);
        chk("final_occ_single", 64'(occ1), 64'd0);
        mon_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
